// File: rtl/risc_v_cpu.sv
// risc_v_cpu: five-stage in-order RV32IM pipeline, IMEM/DMEM inside.
// Ports: CLK (rising edge), RESET (async, active high); no outputs.
module risc_v_alu (
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic [4:0]  SELECT,
  output logic [31:0] RESULT
);
  logic [31:0] ml, mh_ss, mh_su, mh_uu;
  logic        dz, ovf;

  assign ml    = DATA1 * DATA2;
  assign mh_ss = 32'(({{32{DATA1[31]}}, DATA1} *
                      {{32{DATA2[31]}}, DATA2}) >> 32);
  assign mh_su = 32'(({{32{DATA1[31]}}, DATA1} *
                      {32'd0, DATA2}) >> 32);
  assign mh_uu = 32'(({32'd0, DATA1} *
                      {32'd0, DATA2}) >> 32);
  assign dz    = (DATA2 == 32'd0);
  // INT_MIN / -1 overflows; pinned to RISC-V results
  assign ovf   = (DATA1 == 32'h8000_0000) &&
                 (DATA2 == 32'hFFFF_FFFF);

  always_comb begin
    RESULT = '0;
    unique case (SELECT)
      5'd0:  RESULT = DATA1 + DATA2;
      5'd1:  RESULT = DATA1 - DATA2;
      5'd2:  RESULT = DATA1 << DATA2[4:0];
      5'd3:  RESULT = {31'd0,
                       $signed(DATA1) < $signed(DATA2)};
      5'd4:  RESULT = {31'd0, DATA1 < DATA2};
      5'd5:  RESULT = DATA1 ^ DATA2;
      5'd6:  RESULT = DATA1 >> DATA2[4:0];
      5'd7:  RESULT = $signed(DATA1) >>> DATA2[4:0];
      5'd8:  RESULT = DATA1 | DATA2;
      5'd9:  RESULT = DATA1 & DATA2;
      5'd10: RESULT = ml;
      5'd11: RESULT = mh_ss;
      5'd12: RESULT = mh_su;
      5'd13: RESULT = mh_uu;
      5'd14: RESULT = dz  ? 32'hFFFF_FFFF :
                      ovf ? DATA1 :
                      32'($signed(DATA1) / $signed(DATA2));
      5'd15: RESULT = dz ? 32'hFFFF_FFFF : DATA1 / DATA2;
      5'd16: RESULT = dz  ? DATA1 :
                      ovf ? 32'd0 :
                      32'($signed(DATA1) % $signed(DATA2));
      5'd17: RESULT = dz ? DATA1 : DATA1 % DATA2;
      5'd18: RESULT = DATA2;
      default: RESULT = '0;
    endcase
  end
endmodule

module risc_v_cpu (
  input logic CLK,
  input logic RESET
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic       we;
    logic       pc1;
    logic       imm2;
    logic       br;
    logic       jal;
    logic       jalr;
    logic       st;
    logic       ld;
    logic [4:0] alu;
    logic [2:0] f3;
    logic [4:0] rd;
  } ctl_t;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] rf   [32];

  logic [31:0] IF_PC, IFD_INSTR, WB_ADD;
  logic [2:0]  IMME_SELECT;
  logic [4:0]  EX_ALU;
  logic        MUX_OUT;

  logic [31:0] pc_q, pc_d, ifd_pc_q, ifd_instr_q;
  ctl_t        id_ctl, ex_ctl_q;
  logic [31:0] id_imm, rs1_v, rs2_v;
  logic [4:0]  rs1a, rs2a;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] ex_pc_q, ex_a_q, ex_b_q, ex_imm_q;
  logic [31:0] alu_a, alu_b, alu_res, target;
  logic        taken;
  logic [31:0] mem_res_q, mem_sd_q, mem_pc4_q, mem_rdata;
  logic [4:0]  mem_rd_q;
  logic        mem_we_q, mem_st_q, mem_ld_q, mem_lk_q;
  logic [31:0] wb_alu_q, wb_ldd_q, wb_pc4_q;
  logic [4:0]  wb_rd_q;
  logic        wb_we_q, wb_ld_q, wb_lk_q;

  assign IF_PC     = pc_q;
  assign IFD_INSTR = ifd_instr_q;
  assign EX_ALU    = ex_ctl_q.alu;

  function automatic logic [4:0] f3_alu(
    input logic [2:0] f
  );
    logic [4:0] r;
    unique case (f)
      3'd0: r = 5'd0;
      3'd1: r = 5'd2;
      3'd2: r = 5'd3;
      3'd3: r = 5'd4;
      3'd4: r = 5'd5;
      3'd5: r = 5'd6;
      3'd6: r = 5'd8;
      3'd7: r = 5'd9;
    endcase
    return r;
  endfunction

  // IF: PC wraps inside the 1 KiB instruction space
  assign pc_d = (MUX_OUT ? target : pc_q + 32'd4) &
                32'h0000_03FF;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q        <= '0;
      ifd_pc_q    <= '0;
      ifd_instr_q <= NOP;
    end else begin
      pc_q <= pc_d;
      if (MUX_OUT) begin
        ifd_pc_q    <= '0;
        ifd_instr_q <= NOP;
      end else begin
        ifd_pc_q    <= pc_q;
        ifd_instr_q <= imem[pc_q[9:2]];
      end
    end
  end

  // ID
  assign f3   = ifd_instr_q[14:12];
  assign f7   = ifd_instr_q[31:25];
  assign rs1a = ifd_instr_q[19:15];
  assign rs2a = ifd_instr_q[24:20];

  always_comb begin
    id_ctl      = '0;
    id_ctl.f3   = f3;
    id_ctl.rd   = ifd_instr_q[11:7];
    IMME_SELECT = 3'd0;
    unique case (ifd_instr_q[6:0])
      7'h37: begin
        id_ctl.we   = 1'b1;
        id_ctl.imm2 = 1'b1;
        id_ctl.alu  = 5'd18;
        IMME_SELECT = 3'd3;
      end
      7'h17: begin
        id_ctl.we   = 1'b1;
        id_ctl.pc1  = 1'b1;
        id_ctl.imm2 = 1'b1;
        IMME_SELECT = 3'd3;
      end
      7'h6F: begin
        id_ctl.we   = 1'b1;
        id_ctl.jal  = 1'b1;
        id_ctl.pc1  = 1'b1;
        id_ctl.imm2 = 1'b1;
        IMME_SELECT = 3'd4;
      end
      7'h67: begin
        id_ctl.we   = (f3 == 3'd0);
        id_ctl.jalr = (f3 == 3'd0);
        id_ctl.imm2 = 1'b1;
      end
      7'h63: begin
        id_ctl.br   = (f3 != 3'd2) && (f3 != 3'd3);
        IMME_SELECT = 3'd2;
      end
      7'h03: begin
        id_ctl.we   = (f3 == 3'd2);
        id_ctl.ld   = (f3 == 3'd2);
        id_ctl.imm2 = 1'b1;
      end
      7'h23: begin
        id_ctl.st   = (f3 == 3'd2);
        id_ctl.imm2 = 1'b1;
        IMME_SELECT = 3'd1;
      end
      7'h13: begin
        id_ctl.imm2 = 1'b1;
        id_ctl.alu  = f3_alu(f3);
        if (f3 == 3'd1) begin
          id_ctl.we = (f7 == 7'h00);
        end else if (f3 == 3'd5) begin
          id_ctl.we = (f7 == 7'h00) || (f7 == 7'h20);
          if (f7 == 7'h20) id_ctl.alu = 5'd7;
        end else begin
          id_ctl.we = 1'b1;
        end
      end
      7'h33: begin
        if (f7 == 7'h00) begin
          id_ctl.we  = 1'b1;
          id_ctl.alu = f3_alu(f3);
        end else if (f7 == 7'h20 &&
                     (f3 == 3'd0 || f3 == 3'd5)) begin
          id_ctl.we  = 1'b1;
          id_ctl.alu = (f3 == 3'd0) ? 5'd1 : 5'd7;
        end else if (f7 == 7'h01) begin
          id_ctl.we  = 1'b1;
          id_ctl.alu = 5'd10 + {2'd0, f3};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (IMME_SELECT)
      3'd1: id_imm = {{20{ifd_instr_q[31]}},
                      ifd_instr_q[31:25],
                      ifd_instr_q[11:7]};
      3'd2: id_imm = {{19{ifd_instr_q[31]}},
                      ifd_instr_q[31], ifd_instr_q[7],
                      ifd_instr_q[30:25],
                      ifd_instr_q[11:8], 1'b0};
      3'd3: id_imm = {ifd_instr_q[31:12], 12'd0};
      3'd4: id_imm = {{11{ifd_instr_q[31]}},
                      ifd_instr_q[31],
                      ifd_instr_q[19:12],
                      ifd_instr_q[20],
                      ifd_instr_q[30:21], 1'b0};
      default: id_imm = {{20{ifd_instr_q[31]}},
                         ifd_instr_q[31:20]};
    endcase
  end

  // WB data bypasses into the ID read in the same cycle
  assign rs1_v = (rs1a == 5'd0) ? '0 :
                 (wb_we_q && wb_rd_q == rs1a) ? WB_ADD :
                 rf[rs1a];
  assign rs2_v = (rs2a == 5'd0) ? '0 :
                 (wb_we_q && wb_rd_q == rs2a) ? WB_ADD :
                 rf[rs2a];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ex_ctl_q <= '0;
      ex_pc_q  <= '0;
      ex_a_q   <= '0;
      ex_b_q   <= '0;
      ex_imm_q <= '0;
    end else if (MUX_OUT) begin
      ex_ctl_q <= '0;
      ex_pc_q  <= '0;
      ex_a_q   <= '0;
      ex_b_q   <= '0;
      ex_imm_q <= '0;
    end else begin
      ex_ctl_q <= id_ctl;
      ex_pc_q  <= ifd_pc_q;
      ex_a_q   <= rs1_v;
      ex_b_q   <= rs2_v;
      ex_imm_q <= id_imm;
    end
  end

  // EX
  assign alu_a = ex_ctl_q.pc1 ? ex_pc_q : ex_a_q;
  assign alu_b = ex_ctl_q.imm2 ? ex_imm_q : ex_b_q;

  risc_v_alu alu (
    .DATA1  (alu_a),
    .DATA2  (alu_b),
    .SELECT (ex_ctl_q.alu),
    .RESULT (alu_res)
  );

  always_comb begin
    taken = 1'b0;
    unique case (ex_ctl_q.f3)
      3'd0: taken = (ex_a_q == ex_b_q);
      3'd1: taken = (ex_a_q != ex_b_q);
      3'd4: taken = $signed(ex_a_q) < $signed(ex_b_q);
      3'd5: taken = $signed(ex_a_q) >= $signed(ex_b_q);
      3'd6: taken = (ex_a_q < ex_b_q);
      3'd7: taken = (ex_a_q >= ex_b_q);
      default: taken = 1'b0;
    endcase
  end

  assign MUX_OUT = (ex_ctl_q.br & taken) |
                   ex_ctl_q.jal | ex_ctl_q.jalr;
  assign target  = ex_ctl_q.jalr ?
                   (alu_res & ~32'd1) :
                   ex_pc_q + ex_imm_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem_res_q <= '0;
      mem_sd_q  <= '0;
      mem_pc4_q <= '0;
      mem_rd_q  <= '0;
      mem_we_q  <= 1'b0;
      mem_st_q  <= 1'b0;
      mem_ld_q  <= 1'b0;
      mem_lk_q  <= 1'b0;
    end else begin
      mem_res_q <= alu_res;
      mem_sd_q  <= ex_b_q;
      mem_pc4_q <= ex_pc_q + 32'd4;
      mem_rd_q  <= ex_ctl_q.rd;
      mem_we_q  <= ex_ctl_q.we;
      mem_st_q  <= ex_ctl_q.st;
      mem_ld_q  <= ex_ctl_q.ld;
      mem_lk_q  <= ex_ctl_q.jal | ex_ctl_q.jalr;
    end
  end

  // MEM
  assign mem_rdata = dmem[mem_res_q[9:2]];

  always_ff @(posedge CLK) begin
    if (mem_st_q) dmem[mem_res_q[9:2]] <= mem_sd_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wb_alu_q <= '0;
      wb_ldd_q <= '0;
      wb_pc4_q <= '0;
      wb_rd_q  <= '0;
      wb_we_q  <= 1'b0;
      wb_ld_q  <= 1'b0;
      wb_lk_q  <= 1'b0;
    end else begin
      wb_alu_q <= mem_res_q;
      wb_ldd_q <= mem_rdata;
      wb_pc4_q <= mem_pc4_q;
      wb_rd_q  <= mem_rd_q;
      wb_we_q  <= mem_we_q;
      wb_ld_q  <= mem_ld_q;
      wb_lk_q  <= mem_lk_q;
    end
  end

  // WB
  assign WB_ADD = wb_ld_q ? wb_ldd_q :
                  wb_lk_q ? wb_pc4_q : wb_alu_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we_q && wb_rd_q != 5'd0) begin
      rf[wb_rd_q] <= WB_ADD;
    end
  end
endmodule

// File: tb/tb_risc_v_cpu.sv
// tb_risc_v_cpu: directed programs for risc_v_cpu, checked
// against hand-computed register, memory and probe values.
module tb_risc_v_cpu;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] prog [$];

  risc_v_cpu dut (
    .CLK   (CLK),
    .RESET (RESET)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h",
               tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // hold reset, load IMEM, release between edges
  task automatic boot();
    RESET = 1'b1;
    #1;
    for (int i = 0; i < 256; i++)
      dut.imem[i] = (i < prog.size()) ? prog[i] : NOP;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  function automatic logic [31:0] ri(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] rr(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  initial begin
    // arithmetic and M-extension
    prog = '{
      ri(12'd5, 0, 0, 1, 7'h13),
      ri(12'hFFD, 0, 0, 2, 7'h13),
      NOP, NOP,
      rr(7'h00, 2, 1, 0, 3),
      rr(7'h20, 2, 1, 0, 4),
      rr(7'h20, 1, 2, 5, 5),
      ri(12'd7, 0, 0, 6, 7'h13),
      NOP, NOP,
      rr(7'h01, 2, 6, 0, 7),
      rr(7'h01, 0, 6, 4, 8),
      rr(7'h01, 0, 6, 6, 9),
      {20'h80000, 5'd10, 7'h37},
      ri(12'hFFF, 0, 0, 11, 7'h13),
      NOP, NOP,
      rr(7'h01, 11, 11, 3, 12),
      rr(7'h01, 11, 10, 4, 13),
      rr(7'h01, 11, 10, 6, 14),
      rr(7'h01, 2, 6, 1, 15),
      rr(7'h01, 6, 2, 5, 16),
      rr(7'h01, 6, 2, 7, 17)
    };
    boot();
    chk("rst_pc", dut.IF_PC, 32'd0);
    chk("rst_ifd", dut.IFD_INSTR, NOP);
    chk("rst_mux", {31'd0, dut.MUX_OUT}, 32'd0);
    tick(1);
    chk("pc_4", dut.IF_PC, 32'd4);
    chk("isel_i", {29'd0, dut.IMME_SELECT}, 32'd0);
    tick(1);
    chk("pc_8", dut.IF_PC, 32'd8);
    tick(1);
    chk("pc_12", dut.IF_PC, 32'd12);
    tick(3);
    chk("add_d1", dut.alu.DATA1, 32'd5);
    chk("add_d2", dut.alu.DATA2, 32'hFFFF_FFFD);
    chk("add_res", dut.alu.RESULT, 32'd2);
    chk("add_sel", {27'd0, dut.EX_ALU}, 32'd0);
    tick(1);
    chk("sub_res", dut.alu.RESULT, 32'd8);
    chk("sub_sel", {27'd0, dut.EX_ALU}, 32'd1);
    tick(1);
    chk("sra_res", dut.alu.RESULT, 32'hFFFF_FFFF);
    chk("sra_sel", {27'd0, dut.EX_ALU}, 32'd7);
    chk("add_wb", dut.WB_ADD, 32'd2);
    tick(40);
    chk("x3_add", dut.rf[3], 32'd2);
    chk("x4_sub", dut.rf[4], 32'd8);
    chk("x5_sra", dut.rf[5], 32'hFFFF_FFFF);
    chk("x7_mul", dut.rf[7], 32'hFFFF_FFEB);
    chk("x8_div0", dut.rf[8], 32'hFFFF_FFFF);
    chk("x9_rem0", dut.rf[9], 32'd7);
    chk("x12_mulhu", dut.rf[12], 32'hFFFF_FFFE);
    chk("x13_divov", dut.rf[13], 32'h8000_0000);
    chk("x14_remov", dut.rf[14], 32'd0);
    chk("x15_mulh", dut.rf[15], 32'hFFFF_FFFF);
    chk("x16_divu", dut.rf[16], 32'h2492_4924);
    chk("x17_remu", dut.rf[17], 32'd1);

    // store / load
    prog = '{
      {20'h12345, 5'd1, 7'h37},
      NOP, NOP,
      ri(12'h678, 1, 0, 1, 7'h13),
      NOP, NOP,
      {7'd0, 5'd1, 5'd0, 3'd2, 5'd8, 7'h23},
      ri(12'd8, 0, 2, 5, 7'h03)
    };
    boot();
    tick(1);
    chk("isel_u", {29'd0, dut.IMME_SELECT}, 32'd3);
    tick(6);
    chk("isel_s", {29'd0, dut.IMME_SELECT}, 32'd1);
    tick(4);
    chk("lw_wb", dut.WB_ADD, 32'h1234_5678);
    tick(2);
    chk("lw_x5", dut.rf[5], 32'h1234_5678);
    chk("sw_mem", dut.dmem[2], 32'h1234_5678);

    // branch and jal
    prog = '{
      {1'b0, 6'd0, 5'd0, 5'd0, 3'd0, 4'd6, 1'b0, 7'h63},
      ri(12'd1, 0, 0, 2, 7'h13),
      ri(12'd2, 0, 0, 3, 7'h13),
      ri(12'd3, 0, 0, 4, 7'h13),
      NOP, NOP, NOP, NOP,
      {1'b0, 10'd4, 1'b0, 8'd0, 5'd1, 7'h6F},
      ri(12'd9, 0, 0, 6, 7'h13),
      ri(12'd4, 0, 0, 7, 7'h13)
    };
    boot();
    tick(1);
    chk("isel_b", {29'd0, dut.IMME_SELECT}, 32'd2);
    tick(1);
    chk("beq_mux", {31'd0, dut.MUX_OUT}, 32'd1);
    tick(1);
    chk("beq_pc", dut.IF_PC, 32'd12);
    chk("beq_mux0", {31'd0, dut.MUX_OUT}, 32'd0);
    chk("beq_flush", dut.IFD_INSTR, NOP);
    tick(6);
    chk("isel_j", {29'd0, dut.IMME_SELECT}, 32'd4);
    tick(1);
    chk("jal_mux", {31'd0, dut.MUX_OUT}, 32'd1);
    tick(1);
    chk("jal_pc", dut.IF_PC, 32'd40);
    tick(1);
    chk("jal_wb", dut.WB_ADD, 32'h24);
    tick(10);
    chk("jal_x1", dut.rf[1], 32'h24);
    chk("skip_x2", dut.rf[2], 32'd0);
    chk("skip_x3", dut.rf[3], 32'd0);
    chk("tgt_x4", dut.rf[4], 32'd3);
    chk("skip_x6", dut.rf[6], 32'd0);
    chk("tgt_x7", dut.rf[7], 32'd4);

    // asynchronous reset mid-run
    prog = '{
      ri(12'd1, 0, 0, 1, 7'h13),
      ri(12'd2, 0, 0, 2, 7'h13),
      {7'd0, 5'd0, 5'd0, 3'd2, 5'd8, 7'h23}
    };
    boot();
    tick(3);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_pc", dut.IF_PC, 32'd0);
    chk("arst_ifd", dut.IFD_INSTR, NOP);
    repeat (3) @(posedge CLK);
    #1;
    chk("arst_pc_hold", dut.IF_PC, 32'd0);
    chk("arst_x1", dut.rf[1], 32'd0);
    chk("arst_x2", dut.rf[2], 32'd0);
    chk("arst_mem", dut.dmem[2], 32'h1234_5678);
    RESET = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
